// File: rtl/escalonador_rr_if.sv
// Core-to-scheduler bundle: event inputs from the CPU core and the
// scheduler's switch request, process IDs and slot status masks.
interface escalonador_rr_if #(
  parameter int NUM_PROC = 8,
  parameter int PID_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
);
  logic                enable;
  logic                instr_retire;
  logic                proc_create;
  logic [PID_W-1:0]    create_pid;
  logic                proc_end;
  logic                io_block;
  logic                io_done;
  logic [PID_W-1:0]    io_pid;
  logic                switch_ack;
  logic                switch_req;
  logic [PID_W-1:0]    next_pid;
  logic [PID_W-1:0]    current_pid;
  logic                running;
  logic                idle;
  logic [NUM_PROC-1:0] ready_mask;
  logic [NUM_PROC-1:0] blocked_mask;

  modport master (
    output enable, instr_retire, proc_create, create_pid, proc_end,
           io_block, io_done, io_pid, switch_ack,
    input  switch_req, next_pid, current_pid, running, idle,
           ready_mask, blocked_mask
  );

  modport slave (
    input  enable, instr_retire, proc_create, create_pid, proc_end,
           io_block, io_done, io_pid, switch_ack,
    output switch_req, next_pid, current_pid, running, idle,
           ready_mask, blocked_mask
  );
endinterface

// File: rtl/escalonador_rr.sv
// Round-robin process scheduler: tracks ready/blocked slots, enforces the
// instruction quantum and requests context switches from the CPU core.
module escalonador_rr #(
  parameter int NUM_PROC = 8,
  parameter int QUANTUM  = 32
) (
  input  logic             clock,
  input  logic             reset,
  escalonador_rr_if.slave  bus
);
  localparam int PID_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int CNT_W = $clog2(QUANTUM) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SELECT, S_SWITCH} state_t;

  state_t              state_q, state_d;
  logic [NUM_PROC-1:0] ready_q, ready_d;
  logic [NUM_PROC-1:0] blocked_q, blocked_d;
  logic [PID_W-1:0]    cur_q, cur_d;
  logic [PID_W-1:0]    next_q, next_d;
  logic                sreq_q, sreq_d;
  logic [CNT_W-1:0]    qcnt_q, qcnt_d;
  logic                running_q, running_d;
  logic                idle_q, idle_d;
  logic                pick_found;
  logic [PID_W-1:0]    pick_pid;

  // Scan starts just after the current owner so it is considered last.
  function automatic logic [PID_W:0] pick_next(input logic [NUM_PROC-1:0] mask,
                                               input logic [PID_W-1:0] cur);
    logic             found;
    logic [PID_W-1:0] pid;
    int               idx;
    found = 1'b0;
    pid   = '0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      idx = (int'(cur) + k) % NUM_PROC;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pid   = PID_W'(idx);
      end
    end
    return {found, pid};
  endfunction

  always_comb begin
    {pick_found, pick_pid} = pick_next(ready_q, cur_q);
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    blocked_d = blocked_q;
    cur_d     = cur_q;
    next_d    = next_q;
    sreq_d    = sreq_q;
    qcnt_d    = qcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && (ready_q != '0)) state_d = S_SELECT;
      end
      S_RUN: begin
        if (bus.proc_end) begin
          ready_d[cur_q] = 1'b0;
          state_d        = S_SELECT;
        end else if (bus.io_block) begin
          ready_d[cur_q]   = 1'b0;
          blocked_d[cur_q] = 1'b1;
          state_d          = S_SELECT;
        end else if (bus.enable && bus.instr_retire) begin
          if (qcnt_q == CNT_W'(QUANTUM - 1)) state_d = S_SELECT;
          else qcnt_d = qcnt_q + 1'b1;
        end
      end
      S_SELECT: begin
        if (!pick_found) begin
          state_d = S_IDLE;
        end else if (pick_pid == cur_q) begin
          qcnt_d  = '0;
          state_d = S_RUN;
        end else begin
          next_d  = pick_pid;
          sreq_d  = 1'b1;
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        if (bus.switch_ack) begin
          cur_d   = next_q;
          qcnt_d  = '0;
          sreq_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Mask sets come after the FSM clears so a same-cycle create wins.
    if (bus.proc_create) ready_d[bus.create_pid] = 1'b1;
    if (bus.io_done && blocked_q[bus.io_pid]) begin
      blocked_d[bus.io_pid] = 1'b0;
      ready_d[bus.io_pid]   = 1'b1;
    end
    running_d = (state_d == S_RUN);
    idle_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= '0;
      blocked_q <= '0;
      cur_q     <= '0;
      next_q    <= '0;
      sreq_q    <= 1'b0;
      qcnt_q    <= '0;
      running_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      blocked_q <= blocked_d;
      cur_q     <= cur_d;
      next_q    <= next_d;
      sreq_q    <= sreq_d;
      qcnt_q    <= qcnt_d;
      running_q <= running_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.switch_req   = sreq_q;
  assign bus.next_pid     = next_q;
  assign bus.current_pid  = cur_q;
  assign bus.running      = running_q;
  assign bus.idle         = idle_q;
  assign bus.ready_mask   = ready_q;
  assign bus.blocked_mask = blocked_q;
endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr with a cycle model of the scheduling
// rules and literal checkpoints along the scenario.
module tb_escalonador_rr;
  localparam int N = 8;
  localparam int Q = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_on = 1'b0;

  escalonador_rr_if #(.NUM_PROC(N)) bus ();
  escalonador_rr #(.NUM_PROC(N), .QUANTUM(Q)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  // Model: mode 0 waiting, 1 executing, 2 choosing, 3 handing over.
  int m_mode, m_cur, m_nxt, m_cnt;
  bit m_req;
  bit m_rdy[N];
  bit m_blk[N];

  always @(posedge clock) begin
    bit r0[N];
    bit b0[N];
    bit any;
    int pick;
    r0 = m_rdy;
    b0 = m_blk;
    if (reset) begin
      m_mode = 0; m_cur = 0; m_nxt = 0; m_cnt = 0; m_req = 0;
      foreach (m_rdy[i]) begin m_rdy[i] = 0; m_blk[i] = 0; end
    end else begin
      any = 0;
      foreach (r0[i]) any |= r0[i];
      if (m_mode == 0) begin
        if (bus.enable && any) m_mode = 2;
      end else if (m_mode == 1) begin
        if (bus.proc_end) begin
          m_rdy[m_cur] = 0; m_mode = 2;
        end else if (bus.io_block) begin
          m_rdy[m_cur] = 0; m_blk[m_cur] = 1; m_mode = 2;
        end else if (bus.enable && bus.instr_retire) begin
          if (m_cnt + 1 >= Q) m_mode = 2;
          else m_cnt++;
        end
      end else if (m_mode == 2) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && r0[(m_cur + k) % N]) pick = (m_cur + k) % N;
        if (pick < 0) m_mode = 0;
        else if (pick == m_cur) begin m_cnt = 0; m_mode = 1; end
        else begin m_nxt = pick; m_req = 1; m_mode = 3; end
      end else begin
        if (bus.switch_ack) begin
          m_cur = m_nxt; m_cnt = 0; m_req = 0; m_mode = 1;
        end
      end
      if (bus.proc_create) m_rdy[bus.create_pid] = 1;
      if (bus.io_done && b0[bus.io_pid]) begin
        m_blk[bus.io_pid] = 0; m_rdy[bus.io_pid] = 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pack(input bit v[N]);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r |= (1 << i);
    return r;
  endfunction

  always @(negedge clock) begin
    if (chk_on) begin
      chk("m_switch_req", int'(bus.switch_req), int'(m_req));
      chk("m_next_pid", int'(bus.next_pid), m_nxt);
      chk("m_current_pid", int'(bus.current_pid), m_cur);
      chk("m_running", int'(bus.running), int'(m_mode == 1));
      chk("m_idle", int'(bus.idle), int'(m_mode == 0));
      chk("m_ready_mask", int'(bus.ready_mask), pack(m_rdy));
      chk("m_blocked_mask", int'(bus.blocked_mask), pack(m_blk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !bus.switch_req; i++) cyc(1);
    chk("wait_switch_req", int'(bus.switch_req), 1);
  endtask

  task automatic ack_sw();
    bus.switch_ack = 1; cyc(1); bus.switch_ack = 0;
  endtask

  task automatic create(input int pid);
    bus.proc_create = 1; bus.create_pid = 3'(pid); cyc(1); bus.proc_create = 0;
  endtask

  task automatic retire(input int n);
    bus.instr_retire = 1; cyc(n); bus.instr_retire = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1; bus.instr_retire = 0; bus.proc_create = 0; bus.create_pid = '0;
    bus.proc_end = 0; bus.io_block = 0; bus.io_done = 0; bus.io_pid = '0;
    bus.switch_ack = 0;
    cyc(1); chk_on = 1; cyc(2);
    reset = 0;
    chk("rst_idle", int'(bus.idle), 1);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_ready", int'(bus.ready_mask), 0);
    chk("rst_req", int'(bus.switch_req), 0);

    // First switch: lowest ready pid above 0, ack held off.
    bus.proc_create = 1;
    for (int p = 1; p <= 3; p++) begin bus.create_pid = 3'(p); cyc(1); end
    bus.proc_create = 0;
    wait_req();
    chk("first_next", int'(bus.next_pid), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_req", int'(bus.switch_req), 1);
      chk("hold_next", int'(bus.next_pid), 1);
    end
    ack_sw();
    chk("ack_cur", int'(bus.current_pid), 1);
    chk("ack_running", int'(bus.running), 1);

    // Quantum expiry 1 -> 2.
    retire(4);
    wait_req();
    chk("expiry_next", int'(bus.next_pid), 2);
    ack_sw();

    // pid 2 blocks on I/O.
    bus.io_block = 1; cyc(1); bus.io_block = 0;
    chk("blk_mask", int'(bus.blocked_mask), 8'h04);
    chk("blk_ready", int'(bus.ready_mask), 8'h0A);
    wait_req();
    chk("blk_next", int'(bus.next_pid), 3);
    ack_sw();

    // Expiry from 3 wraps to 1.
    retire(4);
    wait_req();
    chk("wrap_next", int'(bus.next_pid), 1);
    ack_sw();

    // io_done for blocked and non-blocked slots; stray ack in RUN.
    bus.io_done = 1; bus.io_pid = 3'd2; cyc(1);
    chk("iodone_blk", int'(bus.blocked_mask), 0);
    chk("iodone_rdy", int'(bus.ready_mask), 8'h0E);
    bus.io_pid = 3'd5; cyc(1); bus.io_done = 0;
    chk("iodone5_rdy", int'(bus.ready_mask), 8'h0E);
    ack_sw();
    chk("stray_ack_cur", int'(bus.current_pid), 1);

    // Reset while in SWITCH.
    retire(4);
    wait_req();
    reset = 1; cyc(1); reset = 0;
    chk("rstsw_req", int'(bus.switch_req), 0);
    chk("rstsw_next", int'(bus.next_pid), 0);
    chk("rstsw_cur", int'(bus.current_pid), 0);
    chk("rstsw_ready", int'(bus.ready_mask), 0);

    // Lone process preempted: no switch request.
    create(1);
    wait_req();
    ack_sw();
    bus.enable = 0; retire(6); bus.enable = 1;
    chk("frozen_running", int'(bus.running), 1);
    retire(4);
    chk("lone_select", int'(bus.running), 0);
    cyc(1);
    chk("lone_run", int'(bus.running), 1);
    chk("lone_req", int'(bus.switch_req), 0);
    chk("lone_cur", int'(bus.current_pid), 1);
    retire(3);
    chk("qcnt_restart", int'(bus.running), 1);
    retire(1);
    cyc(1);

    // Last process ends -> IDLE, then a new process arrives.
    bus.proc_end = 1; cyc(1); bus.proc_end = 0;
    cyc(1);
    chk("end_idle", int'(bus.idle), 1);
    chk("end_ready", int'(bus.ready_mask), 0);
    create(4);
    wait_req();
    chk("new_next", int'(bus.next_pid), 4);
    ack_sw();

    // proc_end beats io_block.
    create(5);
    bus.proc_end = 1; bus.io_block = 1; cyc(1); bus.proc_end = 0; bus.io_block = 0;
    chk("endwin_blk", int'(bus.blocked_mask), 0);
    chk("endwin_rdy", int'(bus.ready_mask), 8'h20);
    wait_req();
    chk("endwin_next", int'(bus.next_pid), 5);
    ack_sw();

    // proc_end with create of the same pid keeps it ready.
    bus.proc_end = 1; bus.proc_create = 1; bus.create_pid = 3'd5; cyc(1);
    bus.proc_end = 0; bus.proc_create = 0;
    chk("recreate_rdy", int'(bus.ready_mask), 8'h20);
    cyc(1);
    chk("recreate_run", int'(bus.running), 1);
    chk("recreate_cur", int'(bus.current_pid), 5);
    cyc(2);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/escalonador_rr.md
# escalonador_rr

Round-robin process scheduler that sequences the CPU's multiprogramming datapath. It tracks which of up to NUM_PROC processes are ready or blocked on I/O, counts retired instructions against a quantum, and decides when the current process must leave the CPU. It then requests a context switch with the next process ID. It sits beside the CPU core: the core reports retire/end/IN events and performs the save/restore routine, and acknowledges via switch_ack.

## Interface
- NUM_PROC, 8: number of process slots; PID_W = clog2(NUM_PROC)
- QUANTUM, 32: retired instructions per time slice; must be ≥ 2; counter width clog2(QUANTUM)+1
- clock  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  scheduler active (BIOS finished); gates IDLE exit and quantum counting
- instr_retire  in  1  one user instruction retired this cycle
- proc_create  in  1  mark create_pid ready
- create_pid  in  PID_W  slot being created
- proc_end  in  1  current process finished
- io_block  in  1  current process issued IN; block it
- io_done  in  1  I/O complete for io_pid
- io_pid  in  PID_W  slot being unblocked
- switch_ack  in  1  core finished context save/restore
- switch_req  out  1  context switch requested; held until ack
- next_pid  out  PID_W  process to load; valid while switch_req=1
- current_pid  out  PID_W  process owning the CPU
- running  out  1  state==RUN
- idle  out  1  state==IDLE (no ready process)
- ready_mask  out  NUM_PROC  bit i = slot i ready
- blocked_mask  out  NUM_PROC  bit i = slot i waiting on I/O

## Operation
- States: IDLE, RUN, SELECT, SWITCH.
- IDLE: if enable && ready_mask!=0 → SELECT.
- RUN, event priority proc_end > io_block > quantum expiry:
  - proc_end: clear ready[current_pid] → SELECT.
  - io_block: clear ready, set blocked[current_pid] → SELECT.
  - Expiry: on instr_retire with enable, q_count+1; when count==QUANTUM-1 and retire → q_count stays, current stays ready → SELECT.
- SELECT (exactly one cycle): search ready_mask starting at current_pid+1, wrapping modulo NUM_PROC, with current_pid checked last.
  - None found → IDLE.
  - Found == current_pid and ready[current_pid]=1 (lone process preempted) → q_count←0, RUN directly, no switch_req.
  - Otherwise next_pid←found, switch_req←1 → SWITCH.
- SWITCH: hold switch_req and next_pid stable. On switch_ack: current_pid←next_pid, q_count←0, switch_req←0 → RUN.
- switch_ack outside SWITCH is ignored. instr_retire, proc_end and io_block outside RUN are ignored.
- Mask updates apply in every state:
  - proc_create sets ready[create_pid]; no effect if already ready.
  - io_done sets ready[io_pid] and clears blocked[io_pid] only if blocked[io_pid]=1; otherwise ignored.
  - Sets are applied after clears in the same cycle. Example: proc_end plus proc_create of the same pid leaves the pid ready.
- A slot set ready while in SWITCH is not considered until the next SELECT.
- enable low in RUN: q_count frozen; proc_end/io_block are still honoured.

## Timing
- Reset (sync): state IDLE; switch_req=0, next_pid=0, current_pid=0, running=0, idle=1, ready_mask=0, blocked_mask=0, q_count=0.
- An event sampled at edge N → state SELECT after N; switch_req=1 after edge N+1.
- Switch path is min 3 cycles from event to RUN: ack sampled at edge N+2 → running=1 and new current_pid after N+2.
- Masks update at the edge where the event is sampled and are visible the next cycle.
- IDLE→SELECT on the first edge where enable && ready_mask!=0. The first switch from reset loads the lowest ready pid ≥1, wrapping to 0 last.
- Reset asserted mid-SWITCH drops switch_req on the next edge. Pending next_pid is discarded.

## Test plan
- Reset, then proc_create pids 1,2,3 with enable=1 → switch_req, next_pid=1. Ack → current_pid=1, running=1. Ack delayed 5 cycles → switch_req stays high and next_pid stays 1 throughout.
- Ready {1,2,3}, QUANTUM=4, current=1, 4 retires → switch_req with next_pid=2. Then current=3 expiry → next_pid=1 (wrap).
- Current=2, io_block → blocked_mask=0b0100, ready bit 2 cleared, next_pid=3. Later io_done io_pid=2 → blocked cleared, ready bit 2 set. io_done io_pid=5 (not blocked) → masks unchanged.
- Only pid 1 ready, quantum expires → SELECT then RUN with no switch_req, q_count=0, current_pid=1.
- Only pid 1 ready, proc_end → IDLE, idle=1, ready_mask=0. Then proc_create pid 4 → switch_req, next_pid=4.
- Same-cycle proc_end and io_block → end wins, blocked_mask unchanged. Same-cycle proc_end and proc_create of current pid → pid remains ready. Reset during SWITCH → all outputs at reset values next cycle.
